// File: rtl/cache_pkg.sv
// Shared types and address-split helpers for the direct-mapped write-through cache.
package cache_pkg;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  function automatic int off_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  // Tag covers everything above the byte offset, word offset and index.
  function automatic int tag_w(input int num_lines, input int words_per_line);
    return ADDR_W - 2 - $clog2(words_per_line) - $clog2(num_lines);
  endfunction

  localparam int DEF_OFF_W = off_w(4);
  localparam int DEF_IDX_W = idx_w(16);
  localparam int DEF_TAG_W = tag_w(16, 4);

endpackage

// File: rtl/cache.sv
// Direct-mapped, write-through, no-write-allocate cache with a word-serial
// refill engine and a single outstanding memory transfer.
module cache
  import cache_pkg::*;
#(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int OW = off_w(WORDS_PER_LINE);
  localparam int IW = idx_w(NUM_LINES);
  localparam int TW = tag_w(NUM_LINES, WORDS_PER_LINE);

  state_t                state_q, state_d;
  logic [OW-1:0]         cnt_q;
  logic [NUM_LINES-1:0]  valid_q;
  logic [TW-1:0]         tag_q  [NUM_LINES];
  logic [DATA_W-1:0]     data_q [NUM_LINES][WORDS_PER_LINE];
  logic [29:0]           waddr_q;
  logic [DATA_W-1:0]     wdata_q;

  logic [29:0]   waddr;
  logic [OW-1:0] off;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          hit, last, unused_bits;

  assign unused_bits = ^cpu_addr[1:0];

  // Live CPU address while idle, the captured one while a transfer is in flight.
  assign waddr = (state_q == IDLE) ? cpu_addr[31:2] : waddr_q;
  assign off   = waddr[OW-1:0];
  assign idx   = waddr[OW+IW-1:OW];
  assign tag   = waddr[29:OW+IW];
  assign hit   = valid_q[idx] && (tag_q[idx] == tag);
  assign last  = (cnt_q == OW'(WORDS_PER_LINE - 1));

  always_comb begin
    state_d   = state_q;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            state_d = WRITE;
          end else if (hit) begin
            cpu_ready = 1'b1;
            cpu_rdata = data_q[idx][off];
          end else begin
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {waddr_q[29:OW], cnt_q, 2'b00};
        if (mem_ack && last) state_d = IDLE;
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {waddr_q, 2'b00};
        mem_wdata = wdata_q;
        if (mem_ack) begin
          cpu_ready = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cpu_req) begin
        waddr_q <= cpu_addr[31:2];
        wdata_q <= cpu_wdata;
      end
      if (state_q == REFILL && mem_ack) begin
        cnt_q <= last ? '0 : cnt_q + 1'b1;
        if (last) valid_q[idx] <= 1'b1;
      end
    end
  end

  // Storage arrays carry no reset; the valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (state_q == REFILL && mem_ack) begin
      data_q[idx][cnt_q] <= mem_rdata;
      if (last) tag_q[idx] <= tag;
    end
    if (state_q == WRITE && mem_ack && hit) begin
      data_q[idx][off] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_cache.sv
// Directed bench for cache: vector table of CPU transactions against a
// behavioural memory responder, plus reset-mid-refill and stray-ack sequences.
module tb_cache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  cache #(.NUM_LINES(16), .WORDS_PER_LINE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [31:0] exp_base;
    int          exp_nmem;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } mop_t;

  mop_t        log_q[$];
  logic [31:0] bmem [0:4095];
  int          budget = -1;
  bit          spur_ack = 1'b0;
  int          n_cmp = 0, n_bad = 0;

  // Memory model: one-cycle ack per request, alternating with an idle cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack = 1'b0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (spur_ack) begin
      mem_ack  = 1'b1;
      spur_ack = 1'b0;
    end else if (mem_req && budget != 0) begin
      mem_ack = 1'b1;
      log_q.push_back('{mem_we, mem_addr, mem_wdata});
      if (mem_we) bmem[mem_addr[13:2]] = mem_wdata;
      else        mem_rdata = bmem[mem_addr[13:2]];
      if (budget > 0) budget--;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output int lat, output bit ok, output bit leak);
    log_q.delete();
    rd = '0; lat = 0; ok = 1'b0; leak = 1'b0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk); #1;
      if (cpu_ready) begin
        rd = cpu_rdata; lat = c; ok = 1'b1;
        break;
      end
      if (cpu_rdata !== 32'h0) leak = 1'b1;
      @(posedge clk);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    logic [31:0] rd;
    int          lat;
    bit          ok, leak;
    do_txn(v.we, v.addr, v.wdata, rd, lat, ok, leak);
    chk({nm, " ready"}, 32'(ok), 32'd1);
    chk({nm, " rdata_idle_zero"}, 32'(leak), 32'd0);
    if (!v.we) chk({nm, " rdata"}, rd, v.exp_rdata);
    if (!v.we && v.exp_nmem == 0) chk({nm, " hit_latency"}, 32'(lat), 32'd0);
    chk({nm, " mem_ops"}, 32'(log_q.size()), 32'(v.exp_nmem));
    for (int k = 0; k < log_q.size() && k < v.exp_nmem; k++) begin
      chk({nm, " mem_we"}, 32'(log_q[k].we), 32'(v.we));
      chk({nm, " mem_addr"}, log_q[k].addr, v.we ? v.exp_base : v.exp_base + 32'(4 * k));
      if (v.we) chk({nm, " mem_wdata"}, log_q[k].data, v.wdata);
    end
  endtask

  vec_t vecs[14];

  initial begin
    for (int w = 0; w < 4096; w++) bmem[w] = 32'h0;
    for (int k = 0; k < 4; k++) begin
      bmem[(32'h100  >> 2) + k] = 32'hA0 + 32'(k);
      bmem[(32'h1100 >> 2) + k] = 32'hB0 + 32'(k);
      bmem[(32'h2200 >> 2) + k] = 32'hC0 + 32'(k);
      bmem[(32'h3F0  >> 2) + k] = 32'hD0 + 32'(k);
      bmem[(32'h500  >> 2) + k] = 32'hE0 + 32'(k);
    end

    //           we    addr          wdata         exp_rdata     exp_base    nmem
    vecs[0]  = '{1'b0, 32'h0000_0104, 32'h0,        32'hA1,        32'h100,  4};
    vecs[1]  = '{1'b0, 32'h0000_010C, 32'h0,        32'hA3,        32'h0,    0};
    vecs[2]  = '{1'b1, 32'h0000_0108, 32'hDEAD_BEEF, 32'h0,        32'h108,  1};
    vecs[3]  = '{1'b0, 32'h0000_0108, 32'h0,        32'hDEAD_BEEF, 32'h0,    0};
    vecs[4]  = '{1'b0, 32'h0000_1100, 32'h0,        32'hB0,        32'h1100, 4};
    vecs[5]  = '{1'b0, 32'h0000_0104, 32'h0,        32'hA1,        32'h100,  4};
    vecs[6]  = '{1'b0, 32'h0000_0108, 32'h0,        32'hDEAD_BEEF, 32'h0,    0};
    vecs[7]  = '{1'b1, 32'h0000_1104, 32'hCAFE_F00D, 32'h0,        32'h1104, 1};
    vecs[8]  = '{1'b0, 32'h0000_0104, 32'h0,        32'hA1,        32'h0,    0};
    vecs[9]  = '{1'b1, 32'h0000_2200, 32'h1234_5678, 32'h0,        32'h2200, 1};
    vecs[10] = '{1'b0, 32'h0000_2200, 32'h0,        32'h1234_5678, 32'h2200, 4};
    vecs[11] = '{1'b0, 32'h0000_2204, 32'h0,        32'hC1,        32'h0,    0};
    vecs[12] = '{1'b0, 32'h0000_03F8, 32'h0,        32'hD2,        32'h3F0,  4};
    vecs[13] = '{1'b0, 32'h0000_03FC, 32'h0,        32'hD3,        32'h0,    0};

    // Held in reset with a pending write request: nothing may leave the block.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0104; cpu_wdata = 32'h5555_AAAA;
    #23;
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    chk("reset cpu_ready", 32'(cpu_ready), 32'd0);
    chk("reset cpu_rdata", cpu_rdata, 32'h0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle mem_req", 32'(mem_req), 32'd0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Stray ack while idle must not disturb anything.
    @(posedge clk); #1;
    spur_ack = 1'b1;
    @(negedge clk); #1;
    chk("stray_ack cpu_ready", 32'(cpu_ready), 32'd0);
    chk("stray_ack mem_req", 32'(mem_req), 32'd0);
    run_vec('{1'b0, 32'h0000_03FC, 32'h0, 32'hD3, 32'h0, 0}, "after_stray");

    // Reset after two refill acks: request drops at once, line stays invalid.
    log_q.delete();
    budget = 2;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0504;
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk); #1;
        if (log_q.size() >= 2) begin seen = 1'b1; break; end
      end
      chk("midrefill two_acks", 32'(seen), 32'd1);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrefill stalled mem_req", 32'(mem_req), 32'd1);
    chk("midrefill stalled mem_addr", mem_addr, 32'h508);
    rst_n = 1'b0; cpu_req = 1'b0;
    #1;
    chk("midrefill reset mem_req", 32'(mem_req), 32'd0);
    chk("midrefill reset mem_addr", mem_addr, 32'h0);
    chk("midrefill reset cpu_ready", 32'(cpu_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    budget = -1;
    rst_n = 1'b1;
    run_vec('{1'b0, 32'h0000_0504, 32'h0, 32'hE1, 32'h500, 4}, "post_reset_refill");
    run_vec('{1'b0, 32'h0000_03F8, 32'h0, 32'hD2, 32'h3F0, 4}, "post_reset_invalid");
    run_vec('{1'b0, 32'h0000_050C, 32'h0, 32'hE3, 32'h0, 0}, "post_reset_hit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache.md
CACHE -- requirements
Module: cache

Interface
REQ-001 The module SHALL have parameter NUM_LINES, default 16, meaning number of direct-mapped lines (power of two).
REQ-002 The module SHALL have parameter WORDS_PER_LINE, default 4, meaning 32-bit words per line (power of two).
REQ-003 The module SHALL have one clock and an asynchronous active-low reset, ports listed first:
  clk  input  1  rising-edge clock for all state
  rst_n  input  1  asynchronous active-low reset
REQ-004 The module SHALL have these CPU-side ports:
  cpu_req  input  1  request valid, held until cpu_ready
  cpu_we  input  1  1 = write word, 0 = read word
  cpu_addr  input  32  byte address; bits [1:0] ignored
  cpu_wdata  input  32  write data
  cpu_rdata  output  32  read data, valid while cpu_ready is high on a read
  cpu_ready  output  1  one-cycle completion strobe
REQ-005 The module SHALL have these memory-side ports:
  mem_req  output  1  memory transfer request
  mem_we  output  1  1 = write, 0 = read
  mem_addr  output  32  word-aligned byte address
  mem_wdata  output  32  write data
  mem_rdata  input  32  read data, valid with mem_ack
  mem_ack  input  1  one-cycle strobe completing the current transfer

Function
REQ-006 The address SHALL split into word offset [3:2], index [7:4] and tag [31:8] at the default parameters, with widths derived from the parameters in general.
REQ-007 Each line SHALL hold a valid bit, a tag and WORDS_PER_LINE data words.
REQ-008 The FSM SHALL have exactly three states: IDLE, REFILL and WRITE.
REQ-009 Read hit in IDLE (cpu_req=1, cpu_we=0, line valid, tag equal) SHALL assert cpu_ready combinationally in the same cycle, with cpu_rdata equal to the addressed word and no memory activity.
REQ-010 Read miss in IDLE SHALL move the FSM to REFILL.
REQ-011 REFILL SHALL read the line-aligned block word by word: mem_req=1, mem_we=0, mem_addr = line base + 4*k for k = 0..WORDS_PER_LINE-1.
REQ-012 In REFILL, mem_addr SHALL advance only on the cycle after each mem_ack, each mem_rdata SHALL be written to word k, and mem_req SHALL stay high between words.
REQ-013 On the last mem_ack of a refill, the tag and valid=1 SHALL be written and the FSM SHALL return to IDLE, where the request completes as a hit in the next cycle.
REQ-014 A write in IDLE SHALL move the FSM to WRITE, giving write-through, no-write-allocate behaviour.
REQ-015 WRITE SHALL drive mem_req=1, mem_we=1, mem_addr=cpu_addr with bits [1:0] cleared, and mem_wdata=cpu_wdata until mem_ack.
REQ-016 On the mem_ack cycle of a write, the module SHALL pulse cpu_ready, update the cached word if the line hits (a miss leaves the cache unchanged) and return to IDLE.
REQ-017 In IDLE with no request, mem_req and cpu_ready SHALL be 0.
REQ-018 mem_ack outside REFILL or WRITE SHALL be ignored.
REQ-019 cpu_rdata SHALL be 0 whenever cpu_ready is low.
REQ-020 cpu_addr, cpu_we and cpu_wdata SHALL be sampled only in IDLE; the CPU holds them stable until cpu_ready.
REQ-021 A new request SHALL be accepted in the cycle after cpu_ready at the earliest.

Reset
REQ-022 While rst_n is low, the module SHALL force the FSM to IDLE, clear all valid bits, clear the refill word counter, and drive cpu_ready, mem_req, mem_we, mem_addr, mem_wdata and cpu_rdata to 0, asynchronously.
REQ-023 Data and tag arrays SHALL not be reset.
REQ-024 Reset during REFILL SHALL leave the line invalid, and reset during WRITE SHALL drop the request without a cpu_ready.

Structure
REQ-025 A shared package cache_pkg SHALL hold the state enum (IDLE, REFILL, WRITE) and the derived width constants (offset, index and tag widths).
REQ-026 The implementation SHALL be a single module with no sub-modules; arrays are plain register arrays.

Verification
REQ-027 After reset, read of 0x0000_0104 -> REFILL issues mem reads 0x100, 0x104, 0x108, 0x10C (memory returns 0xA0..0xA3), then cpu_ready with cpu_rdata=0xA1.
REQ-028 Following read of 0x0000_010C -> cpu_ready in the same cycle, cpu_rdata=0xA3, mem_req stays 0.
REQ-029 Write 0xDEAD_BEEF to 0x0000_0108 (hit) -> one mem write to 0x108, cpu_ready on mem_ack; a later read of 0x108 hits and returns 0xDEAD_BEEF.
REQ-030 Read of 0x0000_1100 (same index, different tag) -> refill of 0x1100..0x110C replaces the line; a subsequent read of 0x104 misses again.
REQ-031 Write to an unmapped line at 0x0000_2200 -> mem write only; a subsequent read of 0x2200 misses and refills.
REQ-032 Assert rst_n low mid-refill after 2 acks -> mem_req drops immediately; after release, reading the same address performs a full 4-word refill.
